// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter for the single register-file read port.
// Registers the returned word with a same-cycle write bypass.
module regfile_read_arbiter #(
   parameter int NREQ = 4,
   parameter int AW   = 5,
   parameter int DW   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*AW-1:0] raddr_i,
   input  logic              stall,
   output logic [NREQ-1:0]   gnt,
   output logic [AW-1:0]     rf_raddr,
   input  logic [DW-1:0]     rf_q,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DW-1:0]     wdata,
   output logic [DW-1:0]     rdata,
   output logic [NREQ-1:0]   rvalid
);

   localparam int          PW = $clog2(NREQ);
   localparam int unsigned N  = NREQ;

   logic [PW-1:0] ptr;
   logic [PW-1:0] win;
   logic [PW-1:0] ptr_nxt;
   logic [PW-1:0] sel;
   logic          hit;
   logic [AW-1:0] addr_a [NREQ];
   logic [DW-1:0] rdata_d;
   int unsigned   idx;

   always_comb begin
      for (int unsigned i = 0; i < N; i++) begin
         addr_a[i] = raddr_i[i*AW +: AW];
      end
   end

   // Scan from ptr upward with wraparound; the first active request wins.
   always_comb begin
      hit = 1'b0;
      win = '0;
      idx = 0;
      sel = '0;
      if (rst_n && !stall) begin
         for (int unsigned k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
               idx = idx - N;
            end
            sel = PW'(idx);
            if (!hit && req[sel]) begin
               hit = 1'b1;
               win = sel;
            end
         end
      end
   end

   always_comb begin
      gnt = '0;
      for (int unsigned i = 0; i < N; i++) begin
         gnt[i] = hit && (win == PW'(i));
      end
      rf_raddr = hit ? addr_a[win] : '0;
      ptr_nxt  = (win == PW'(N - 1)) ? '0 : win + 1'b1;
      // A write committing this edge to the address being read must win over the stale mux output.
      rdata_d  = (we && (waddr == rf_raddr)) ? wdata : rf_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr    <= '0;
         rdata  <= '0;
         rvalid <= '0;
      end else begin
         rvalid <= gnt;
         if (hit) begin
            ptr   <= ptr_nxt;
            rdata <= rdata_d;
         end
      end
   end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter: reset, round-robin, stall,
// bypass, continuous single requester and mid-operation reset.
module tb_regfile_read_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [19:0] raddr_i;
   logic        stall;
   logic [3:0]  gnt;
   logic [4:0]  rf_raddr;
   logic [31:0] rf_q;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [3:0]  rvalid;

   int checks = 0;
   int errors = 0;

   logic [3:0] rr_g [6];
   logic [4:0] rr_a [6];

   regfile_read_arbiter #(.NREQ(4), .AW(5), .DW(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .raddr_i  (raddr_i),
      .stall    (stall),
      .gnt      (gnt),
      .rf_raddr (rf_raddr),
      .rf_q     (rf_q),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .rdata    (rdata),
      .rvalid   (rvalid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_addr(input int i, input logic [4:0] a);
      raddr_i[i*5 +: 5] = a;
   endtask

   // Inputs are applied at the falling edge before calling; checks the
   // combinational grant, then the registered result after the rising edge.
   task automatic cyc(input string tag, input logic [3:0] eg, input logic [4:0] ea,
                      input logic [3:0] ev, input logic [31:0] ed);
      #1;
      chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
      chk({tag, "_raddr"}, 32'(rf_raddr), 32'(ea));
      @(posedge clk);
      #1;
      chk({tag, "_rvalid"}, 32'(rvalid), 32'(ev));
      chk({tag, "_rdata"}, rdata, ed);
      @(negedge clk);
   endtask

   initial begin
      rr_g[0] = 4'b0001; rr_g[1] = 4'b0010; rr_g[2] = 4'b0100;
      rr_g[3] = 4'b1000; rr_g[4] = 4'b0001; rr_g[5] = 4'b0010;
      rr_a[0] = 5'd3;    rr_a[1] = 5'd5;    rr_a[2] = 5'd7;
      rr_a[3] = 5'd11;   rr_a[4] = 5'd3;    rr_a[5] = 5'd5;

      rst_n = 1'b0; req = 4'b1111; stall = 1'b0; we = 1'b0;
      waddr = '0; wdata = '0; rf_q = 32'hFFFF_FFFF; raddr_i = '0;
      set_addr(0, 5'd3); set_addr(1, 5'd5); set_addr(2, 5'd7); set_addr(3, 5'd11);

      // Held in reset across an edge with all requests active.
      @(posedge clk);
      #1;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_raddr", 32'(rf_raddr), 32'h0);
      chk("rst_rvalid", 32'(rvalid), 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int c = 0; c < 6; c++) begin
         rf_q = 32'h1000_0000 + 32'(c);
         cyc("rr", rr_g[c], rr_a[c], rr_g[c], 32'h1000_0000 + 32'(c));
      end

      // ptr is now 2.
      req = 4'b0110; stall = 1'b1; rf_q = 32'h2000_00FF;
      cyc("stall0", 4'b0000, 5'd0, 4'b0000, 32'h1000_0005);
      cyc("stall1", 4'b0000, 5'd0, 4'b0000, 32'h1000_0005);
      stall = 1'b0; rf_q = 32'h2000_0002;
      cyc("unstall_r2", 4'b0100, 5'd7, 4'b0100, 32'h2000_0002);
      rf_q = 32'h2000_0001;
      cyc("unstall_r1", 4'b0010, 5'd5, 4'b0010, 32'h2000_0001);

      req = 4'b0100; rf_q = 32'hDEAD_BEEF;
      cyc("single", 4'b0100, 5'd7, 4'b0100, 32'hDEAD_BEEF);
      req = 4'b0000; rf_q = 32'h0;
      cyc("single_idle", 4'b0000, 5'd0, 4'b0000, 32'hDEAD_BEEF);

      set_addr(0, 5'd9); req = 4'b0001; rf_q = 32'h0;
      we = 1'b1; waddr = 5'd9; wdata = 32'h1234_5678;
      cyc("bypass_hit", 4'b0001, 5'd9, 4'b0001, 32'h1234_5678);
      waddr = 5'd10;
      cyc("bypass_miss", 4'b0001, 5'd9, 4'b0001, 32'h0);
      set_addr(0, 5'd0); waddr = 5'd0; wdata = 32'hCAFE_F00D; rf_q = 32'h1;
      cyc("bypass_a0", 4'b0001, 5'd0, 4'b0001, 32'hCAFE_F00D);
      req = 4'b0000; wdata = 32'h55;
      cyc("we_nogrant", 4'b0000, 5'd0, 4'b0000, 32'hCAFE_F00D);
      we = 1'b0;

      req = 4'b1000;
      for (int c = 0; c < 3; c++) begin
         rf_q = 32'h3000_0000 + 32'(c);
         cyc("cont", 4'b1000, 5'd11, 4'b1000, 32'h3000_0000 + 32'(c));
      end

      // Asynchronous reset pulsed between edges right after a grant.
      set_addr(0, 5'd3);
      req = 4'b0010; rf_q = 32'h4444_4444;
      #1;
      chk("mid_gnt", 32'(gnt), 32'b0010);
      @(posedge clk);
      #1;
      chk("mid_rvalid_pre", 32'(rvalid), 32'b0010);
      chk("mid_rdata_pre", rdata, 32'h4444_4444);
      #1;
      rst_n = 1'b0; req = 4'b1111;
      #1;
      chk("mid_rvalid_rst", 32'(rvalid), 32'h0);
      chk("mid_rdata_rst", rdata, 32'h0);
      chk("mid_gnt_rst", 32'(gnt), 32'h0);
      @(negedge clk);
      rst_n = 1'b1; rf_q = 32'h5555_5555;
      cyc("post_rst0", 4'b0001, 5'd3, 4'b0001, 32'h5555_5555);
      rf_q = 32'h6666_6666;
      cyc("post_rst1", 4'b0010, 5'd5, 4'b0010, 32'h6666_6666);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_read_arbiter.md
# regfile_read_arbiter

Shares the single read port of the 32 x 32-bit register file among NREQ requesters. It drives the read-mux select from a round-robin winner and captures the returned word into an output register. A write-port bypass keeps returned data coherent with a write landing in the same cycle. It sits between the register-file read mux and the pipeline units that need operand reads: decode, debug access and others.

## Interface

Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 5, register address width (matches the 32-entry file)
- DW, 32, data width

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset; asynchronous assert, active-low
- req  input  NREQ  per-requester read request, level
- raddr_i  input  NREQ*AW  packed addresses; requester i occupies bits [i*AW +: AW]
- stall  input  1  when high, blocks all grants this cycle
- gnt  output  NREQ  one-hot grant, combinational, same cycle as the winning req
- rf_raddr  output  AW  select to the read mux; winner's address, or 0 when no grant
- rf_q  input  DW  combinational read data from the mux
- we  input  1  register-file write enable for this cycle (commits at the rising edge)
- waddr  input  AW  write address
- wdata  input  DW  write data
- rdata  output  DW  registered read data
- rvalid  output  NREQ  registered one-hot; identifies the owner of rdata

## Operation

State:
- ptr: round-robin pointer, width clog2(NREQ); the highest-priority requester index.
- Output registers: rdata and rvalid.

Arbitration (combinational, every cycle):
- With stall=0, the winner is the first i with req[i]=1, scanning ptr, ptr+1, … mod NREQ.
- gnt[winner]=1; all other gnt bits are 0.
- No req, or stall=1, or rst_n=0: gnt=0 and rf_raddr=0.

Pointer update (rising edge, on a grant only):
- ptr <= (winner+1) mod NREQ.
- No grant: ptr holds.

Data capture (rising edge):
- On a grant:
  - rdata <= (we && waddr==rf_raddr) ? wdata : rf_q.
  - rvalid <= gnt.
- No grant: rvalid <= 0 and rdata holds its previous value.

Requester rules:
- Hold req and raddr_i stable until gnt is sampled high.
- Keeping req high after a grant issues another read; it is re-arbitrated fairly.
- No transaction is ever dropped or duplicated. Exactly one rvalid pulse follows each gnt cycle.

Reset (rst_n low, asynchronous, any time):
- ptr=0, rdata=0, rvalid=0; gnt forced to 0.
- A grant issued in the cycle reset asserts is discarded; no rvalid follows it.
- On release, the first edge with rst_n=1 arbitrates normally starting from ptr=0.

Boundary conditions:
- Bypass covers every address, including 0; the register file has no hardwired zero register.
- we with waddr != rf_raddr does not affect rdata.
- A single requester asserting continuously is granted every cycle (throughput 1 read/cycle).
- stall and req together: no grant; the requester keeps waiting.

## Timing

- Grant latency: 0 cycles. gnt is high in the same cycle as req when that requester wins.
- Data latency: 1 cycle. rdata/rvalid are valid in the cycle after gnt and held for exactly one cycle; rdata then holds but is meaningless while rvalid=0.
- Fairness: with all NREQ requesters asserting, any requester waits at most NREQ-1 cycles for a grant.
- rf_raddr→rf_q is a combinational path inside one cycle. The bypass compare and mux sit on it, ahead of the rdata register.

## Test plan

- Reset: rst_n=0, req=4'b1111 → gnt=0, rvalid=0, rdata=0. Release → first grant goes to requester 0.
- Single read: req=4'b0100, raddr_i[2]=7, rf_q=32'hDEADBEEF → in the same cycle gnt=4'b0100 and rf_raddr=7. Next cycle rvalid=4'b0100 and rdata=32'hDEADBEEF; the cycle after that, rvalid=0.
- Round-robin: req=4'b1111 held for 6 cycles from reset → gnt sequence 0001, 0010, 0100, 1000, 0001, 0010, with rvalid following one cycle behind each.
- Bypass: requester 0 reads address 9 with rf_q=0, while we=1, waddr=9, wdata=32'h12345678 → rdata=32'h12345678. Repeat with waddr=10 → rdata=0.
- Stall: ptr=2, req=4'b0110, stall=1 for 2 cycles → gnt=0 and rvalid=0 throughout, ptr unchanged. stall=0 → gnt=4'b0100 (requester 2), then requester 1.
- Mid-operation reset: pulse rst_n low between edges in the cycle after a grant → rvalid and rdata clear immediately without waiting for a clock edge. After release, arbitration restarts at requester 0.
